riscv_mul: RTL and testbench

- Bit-serial shift-add multiplier for the RV M-extension multiply group: MUL, MULH, MULHSU, MULHU and, for RV64, MULW.
- Companion to the restoring divider. It sits in the EX stage beside it and uses the same operand, stall and bubble interface toward ID and WB.
- Takes XLEN (or 32, for MULW) iteration cycles plus one result cycle. It stalls the pipeline while busy.

---
 rtl/riscv_pkg.sv | 71 +++++++
 rtl/riscv_mul.sv | 168 ++++++++++++++++
 tb/tb_riscv_mul.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg : shared RV encodings, XLEN codes and multiply-unit types
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  // misa.MXL style XLEN codes
  localparam logic [1:0] XL_RV32I = 2'd1;
  localparam logic [1:0] XL_RV64I = 2'd2;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [2:0] F3_MUL     = 3'b000;
  localparam logic [2:0] F3_MULH    = 3'b001;
  localparam logic [2:0] F3_MULHSU  = 3'b010;
  localparam logic [2:0] F3_MULHU   = 3'b011;
  localparam logic [2:0] F3_DIV     = 3'b100;
  localparam logic [2:0] F3_DIVU    = 3'b101;
  localparam logic [2:0] F3_REM     = 3'b110;
  localparam logic [2:0] F3_REMU    = 3'b111;

  typedef enum logic [2:0] {
    MOP_NONE   = 3'd0,
    MOP_MUL    = 3'd1,
    MOP_MULH   = 3'd2,
    MOP_MULHSU = 3'd3,
    MOP_MULHU  = 3'd4,
    MOP_MULW   = 3'd5
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RES  = 2'd2
  } mul_state_e;

  // key = {xlen32, func7, func3, opcode}
  function automatic mul_op_e mul_decode(input logic [17:0] key);
    logic       xlen32;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [6:0] opc;
    mul_op_e    op;
    xlen32 = key[17];
    f7     = key[16:10];
    f3     = key[9:7];
    opc    = key[6:0];
    op     = MOP_NONE;
    if (f7 == F7_MULDIV) begin
      if (opc == OPC_OP) begin
        case (f3)
          F3_MUL:    op = MOP_MUL;
          F3_MULH:   op = MOP_MULH;
          F3_MULHSU: op = MOP_MULHSU;
          F3_MULHU:  op = MOP_MULHU;
          default:   op = MOP_NONE;
        endcase
      end else if (opc == OPC_OP32 && f3 == F3_MUL && !xlen32) begin
        op = MOP_MULW;
      end
    end
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_mul.sv
// ============================================================================
// riscv_mul : bit-serial shift-add multiplier for MUL/MULH/MULHSU/MULHU/MULW
// Rev 1.0
// ============================================================================
`default_nettype none

module riscv_mul
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            ex_stall,
  output logic            mul_stall,
  input  logic            id_bubble,
  input  logic [XLEN-1:0] id_instr,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic [1:0]      st_xlen,
  output logic            mul_bubble,
  output logic [XLEN-1:0] mul_r
);

  localparam int CW = $clog2(XLEN);
  localparam int W2 = 2 * XLEN;

  function automatic logic [W2-1:0] twos(input logic [W2-1:0] x);
    return ~x + 1'b1;
  endfunction

  function automatic logic [XLEN-1:0] abs(input logic [XLEN-1:0] x);
    return x[XLEN-1] ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    return XLEN'($signed(x));
  endfunction

  mul_state_e      state;
  mul_state_e      state_nxt;
  mul_op_e         op;
  mul_op_e         dec_op;
  logic            neg;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] prod_hi;
  logic [XLEN-1:0] prod_lo;
  logic [CW-1:0]   cnt;

  logic            xlen32;
  logic            accept;
  logic            load;
  logic            step;
  logic            write_res;
  logic            sign_a;
  logic            sign_b;
  logic            neg_in;
  logic [XLEN-1:0] mcand_in;
  logic [XLEN-1:0] plo_in;
  logic [CW-1:0]   cnt_in;
  logic [XLEN:0]   sum;
  logic [W2-1:0]   prod_signed;
  logic [XLEN-1:0] result;
  logic            unused_instr_mid;

  assign unused_instr_mid = ^{id_instr[24:15], id_instr[11:7]};

  if (XLEN > 32) begin : g_instr_hi
    logic unused_instr_hi;
    assign unused_instr_hi = ^id_instr[XLEN-1:32];
  end

  assign xlen32 = (st_xlen == XL_RV32I);
  assign dec_op = mul_decode({xlen32, id_instr[31:25], id_instr[14:12], id_instr[6:0]});
  assign accept = (state == ST_IDLE) && !ex_stall && !id_bubble && (dec_op != MOP_NONE);

  // Operand conditioning at accept; MULW works on the zero-extended low words
  always_comb begin
    sign_a = 1'b0;
    sign_b = 1'b0;
    case (dec_op)
      MOP_MUL, MOP_MULH: begin
        sign_a = 1'b1;
        sign_b = 1'b1;
      end
      MOP_MULHSU: sign_a = 1'b1;
      default: ;
    endcase
    neg_in = (sign_a & opA[XLEN-1]) ^ (sign_b & opB[XLEN-1]);
    if (dec_op == MOP_MULW) begin
      mcand_in = XLEN'(opA[31:0]);
      plo_in   = XLEN'(opB[31:0]);
      cnt_in   = CW'(31);
    end else begin
      mcand_in = sign_a ? abs(opA) : opA;
      plo_in   = sign_b ? abs(opB) : opB;
      cnt_in   = CW'(XLEN - 1);
    end
  end

  assign sum = {1'b0, prod_hi} + ({1'b0, mcand} & {(XLEN+1){prod_lo[0]}});

  // After 32 steps a MULW product's low word sits in the top half of prod_lo
  always_comb begin
    prod_signed = neg ? twos({prod_hi, prod_lo}) : {prod_hi, prod_lo};
    case (op)
      MOP_MUL:  result = prod_signed[XLEN-1:0];
      MOP_MULW: result = sext32(prod_lo[XLEN-1:XLEN-32]);
      default:  result = prod_signed[W2-1:XLEN];
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_MUL;
      ST_MUL:  if (cnt == '0) state_nxt = ST_RES;
      ST_RES:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mul_stall = (state != ST_IDLE);
    load      = accept;
    step      = (state == ST_MUL);
    write_res = (state == ST_RES);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op         <= MOP_NONE;
      neg        <= 1'b0;
      mcand      <= '0;
      prod_hi    <= '0;
      prod_lo    <= '0;
      cnt        <= '0;
      mul_r      <= '0;
      mul_bubble <= 1'b1;
    end else begin
      mul_bubble <= 1'b1;
      if (load) begin
        op      <= dec_op;
        neg     <= neg_in;
        mcand   <= mcand_in;
        prod_hi <= '0;
        prod_lo <= plo_in;
        cnt     <= cnt_in;
      end
      if (step) begin
        {prod_hi, prod_lo} <= {sum, prod_lo[XLEN-1:1]};
        cnt                <= cnt - 1'b1;
      end
      if (write_res) begin
        mul_r      <= result;
        mul_bubble <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_riscv_mul.sv
// ============================================================================
// tb_riscv_mul : directed-vector bench for riscv_mul at XLEN=32 and XLEN=64
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_riscv_mul;

  localparam logic [1:0] XL32 = 2'd1;
  localparam logic [1:0] XL64 = 2'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  logic        ex_stall32, id_bubble32, mul_stall32, mul_bubble32;
  logic [31:0] instr32, opA32, opB32, mul_r32;
  logic [1:0]  st_xlen32;

  logic        ex_stall64, id_bubble64, mul_stall64, mul_bubble64;
  logic [63:0] instr64, opA64, opB64, mul_r64;
  logic [1:0]  st_xlen64;

  int vectors = 0;
  int miscompares = 0;

  riscv_mul #(.XLEN(32)) dut32 (
    .clk(clk), .rstn(rstn), .ex_stall(ex_stall32), .mul_stall(mul_stall32),
    .id_bubble(id_bubble32), .id_instr(instr32), .opA(opA32), .opB(opB32),
    .st_xlen(st_xlen32), .mul_bubble(mul_bubble32), .mul_r(mul_r32)
  );

  riscv_mul #(.XLEN(64)) dut64 (
    .clk(clk), .rstn(rstn), .ex_stall(ex_stall64), .mul_stall(mul_stall64),
    .id_bubble(id_bubble64), .id_instr(instr64), .opA(opA64), .opB(opB64),
    .st_xlen(st_xlen64), .mul_bubble(mul_bubble64), .mul_r(mul_r64)
  );

  // R-type word with rd=x3, rs1=x1, rs2=x2
  function automatic logic [31:0] enc(input logic [2:0] f3, input logic [6:0] opc);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  logic [31:0] I_MUL, I_MULH, I_MULHSU, I_MULHU, I_MULW;

  task automatic drive(input bit w64, input logic [31:0] instr, input logic [63:0] a,
                       input logic [63:0] b, input logic [1:0] xl, input logic exs,
                       input logic idb);
    if (w64) begin
      instr64 = {32'h0, instr}; opA64 = a; opB64 = b; st_xlen64 = xl;
      ex_stall64 = exs; id_bubble64 = idb;
    end else begin
      instr32 = instr; opA32 = a[31:0]; opB32 = b[31:0]; st_xlen32 = xl;
      ex_stall32 = exs; id_bubble32 = idb;
    end
  endtask

  // Called #1 after the accept edge; samples a fixed window of n+6 cycles
  task automatic collect(input bit w64, input int n, output logic [63:0] res,
                         output int stall_n, output int bub_n, output bit order_ok,
                         output bit held);
    logic        ms, mb;
    logic [63:0] r;
    stall_n = 0; bub_n = 0; order_ok = 1'b0; res = '0;
    for (int i = 0; i < n + 6; i++) begin
      ms = w64 ? mul_stall64 : mul_stall32;
      mb = w64 ? mul_bubble64 : mul_bubble32;
      r  = w64 ? mul_r64 : {32'h0, mul_r32};
      if (ms) stall_n++;
      if (!mb) begin
        bub_n++;
        res = r;
        if (i == n + 1 && !ms) order_ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    r    = w64 ? mul_r64 : {32'h0, mul_r32};
    held = (r == res);
  endtask

  task automatic run_op(input bit w64, input logic [31:0] instr, input logic [63:0] a,
                        input logic [63:0] b, input logic [1:0] xl, input int n,
                        output logic [63:0] res, output int stall_n, output int bub_n,
                        output bit order_ok, output bit held);
    @(posedge clk); #1;
    drive(w64, instr, a, b, xl, 1'b0, 1'b0);
    @(posedge clk); #1;
    id_bubble32 = 1'b1; id_bubble64 = 1'b1;
    collect(w64, n, res, stall_n, bub_n, order_ok, held);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive(1'b0, 32'h0, 64'h0, 64'h0, XL32, 1'b0, 1'b1);
    drive(1'b1, 32'h0, 64'h0, 64'h0, XL64, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({mul_stall32, mul_bubble32, mul_r32} !== {1'b0, 1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL reset32: stall=%b bubble=%b r=%h want 0 1 0", mul_stall32, mul_bubble32, mul_r32);
    end
    vectors++;
    if ({mul_stall64, mul_bubble64, mul_r64} !== {1'b0, 1'b1, 64'h0}) begin
      miscompares++;
      $display("FAIL reset64: stall=%b bubble=%b r=%h want 0 1 0", mul_stall64, mul_bubble64, mul_r64);
    end
    rstn = 1'b1;
  endtask

  task automatic test_mul32();
    logic [63:0] res; int sn, bn; bit ok, held;
    run_op(1'b0, I_MUL, 64'd7, 64'hFFFF_FFFD, XL32, 32, res, sn, bn, ok, held);
    vectors++;
    if (res[31:0] !== 32'hFFFF_FFEB) begin
      miscompares++; $display("FAIL mul_7x-3: got %h want ffffffeb", res[31:0]);
    end
    vectors++;
    if (sn != 33) begin miscompares++; $display("FAIL mul_stall_len: got %0d want 33", sn); end
    vectors++;
    if (bn != 1) begin miscompares++; $display("FAIL mul_bubble_len: got %0d want 1", bn); end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL mul_bubble_pos: got 0 want 1"); end
    vectors++;
    if (!held) begin miscompares++; $display("FAIL mul_r_hold: got 0 want 1"); end
  endtask

  task automatic test_mulh_family();
    logic [63:0] res; int sn, bn; bit ok, held;
    run_op(1'b0, I_MULH, 64'h8000_0000, 64'h8000_0000, XL32, 32, res, sn, bn, ok, held);
    vectors++;
    if (res[31:0] !== 32'h4000_0000) begin
      miscompares++; $display("FAIL mulh_min: got %h want 40000000", res[31:0]);
    end
    run_op(1'b0, I_MULHU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, XL32, 32, res, sn, bn, ok, held);
    vectors++;
    if (res[31:0] !== 32'hFFFF_FFFE) begin
      miscompares++; $display("FAIL mulhu_max: got %h want fffffffe", res[31:0]);
    end
    run_op(1'b0, I_MUL, 64'hFFFF_FFFF, 64'hFFFF_FFFF, XL32, 32, res, sn, bn, ok, held);
    vectors++;
    if (res[31:0] !== 32'h0000_0001) begin
      miscompares++; $display("FAIL mul_m1m1: got %h want 00000001", res[31:0]);
    end
  endtask

  task automatic test_mulhsu();
    logic [63:0] res; int sn, bn; bit ok, held;
    run_op(1'b0, I_MULHSU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, XL32, 32, res, sn, bn, ok, held);
    vectors++;
    if (res[31:0] !== 32'hFFFF_FFFF) begin
      miscompares++; $display("FAIL mulhsu_neg: got %h want ffffffff", res[31:0]);
    end
    run_op(1'b0, I_MULHSU, 64'd2, 64'h8000_0000, XL32, 32, res, sn, bn, ok, held);
    vectors++;
    if (res[31:0] !== 32'h0000_0001) begin
      miscompares++; $display("FAIL mulhsu_pos: got %h want 00000001", res[31:0]);
    end
  endtask

  task automatic test_rv64();
    logic [63:0] res; int sn, bn, busy; bit ok, held;
    run_op(1'b1, I_MULW, 64'h1234_5678_7FFF_FFFF, 64'd2, XL64, 32, res, sn, bn, ok, held);
    vectors++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      miscompares++; $display("FAIL mulw: got %h want fffffffffffffffe", res);
    end
    vectors++;
    if (sn != 33) begin miscompares++; $display("FAIL mulw_stall_len: got %0d want 33", sn); end
    run_op(1'b1, I_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, XL64, 64,
           res, sn, bn, ok, held);
    vectors++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      miscompares++; $display("FAIL mulhu64: got %h want fffffffffffffffe", res);
    end
    vectors++;
    if (sn != 65 || bn != 1) begin
      miscompares++; $display("FAIL mulhu64_timing: stall=%0d bubble=%0d want 65 1", sn, bn);
    end
    // MULW is not legal while running in 32-bit mode
    @(posedge clk); #1;
    drive(1'b1, I_MULW, 64'h1234_5678_7FFF_FFFF, 64'd2, XL32, 1'b0, 1'b0);
    busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (mul_stall64 || !mul_bubble64) busy++;
    end
    id_bubble64 = 1'b1;
    vectors++;
    if (busy != 0) begin miscompares++; $display("FAIL mulw_rv32: busy cycles %0d want 0", busy); end
  endtask

  task automatic test_gating();
    logic [63:0] res; int sn, bn, busy; bit ok, held;
    @(posedge clk); #1;
    drive(1'b0, I_MUL, 64'd5, 64'd6, XL32, 1'b1, 1'b0);
    busy = 0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (mul_stall32) busy++; end
    vectors++;
    if (busy != 0) begin miscompares++; $display("FAIL gate_ex_stall: busy %0d want 0", busy); end
    ex_stall32 = 1'b0; id_bubble32 = 1'b1;
    busy = 0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (mul_stall32) busy++; end
    vectors++;
    if (busy != 0) begin miscompares++; $display("FAIL gate_id_bubble: busy %0d want 0", busy); end
    id_bubble32 = 1'b0;
    @(posedge clk); #1;
    id_bubble32 = 1'b1;
    collect(1'b0, 32, res, sn, bn, ok, held);
    vectors++;
    if (res[31:0] !== 32'd30 || sn != 33) begin
      miscompares++; $display("FAIL gate_release: got %h/%0d want 0000001e/33", res[31:0], sn);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] res; int sn, bn; bit ok, held, found;
    @(posedge clk); #1;
    drive(1'b0, I_MUL, 64'd9, 64'd9, XL32, 1'b0, 1'b0);
    @(posedge clk); #1;
    id_bubble32 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (!mul_bubble32) begin
        found = 1'b1;
        vectors++;
        if (mul_r32 !== 32'd81) begin
          miscompares++; $display("FAIL b2b_first: got %h want 00000051", mul_r32);
        end
        drive(1'b0, I_MULHU, 64'hFFFF_FFFF, 64'd2, XL32, 1'b0, 1'b0);
      end else begin
        @(posedge clk); #1;
      end
    end
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL b2b_timeout: got no result want result within 40 cycles");
    end else begin
      @(posedge clk); #1;
      id_bubble32 = 1'b1;
      collect(1'b0, 32, res, sn, bn, ok, held);
      vectors++;
      if (res[31:0] !== 32'd1 || sn != 33) begin
        miscompares++; $display("FAIL b2b_second: got %h/%0d want 00000001/33", res[31:0], sn);
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [63:0] res; int sn, bn; bit ok, held;
    @(posedge clk); #1;
    drive(1'b0, I_MUL, 64'd3, 64'd5, XL32, 1'b0, 1'b0);
    @(posedge clk); #1;
    id_bubble32 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    vectors++;
    if ({mul_stall32, mul_bubble32, mul_r32} !== {1'b0, 1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_midop: stall=%b bubble=%b r=%h want 0 1 0", mul_stall32, mul_bubble32, mul_r32);
    end
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    run_op(1'b0, I_MULHU, 64'h0001_0000, 64'h0001_0000, XL32, 32, res, sn, bn, ok, held);
    vectors++;
    if (res[31:0] !== 32'h0000_0001 || sn != 33) begin
      miscompares++; $display("FAIL after_reset: got %h/%0d want 00000001/33", res[31:0], sn);
    end
  endtask

  initial begin
    I_MUL    = enc(3'b000, 7'b0110011);
    I_MULH   = enc(3'b001, 7'b0110011);
    I_MULHSU = enc(3'b010, 7'b0110011);
    I_MULHU  = enc(3'b011, 7'b0110011);
    I_MULW   = enc(3'b000, 7'b0111011);
    test_reset();
    test_mul32();
    test_mulh_family();
    test_mulhsu();
    test_rv64();
    test_gating();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
